// File: rtl/cprv_dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package cprv_dmem_pkg;

  typedef enum logic [1:0] {DMEM_IDLE, DMEM_WAIT, DMEM_RESP} dmem_state_t;

  localparam int unsigned LAT_CNT_W = 4;

endpackage

// File: rtl/cprv_dmem_array.sv
// Synchronous single-port word RAM with a registered read port; storage is never reset.
module cprv_dmem_array #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Read register only updates on loads, so it keeps the last load result during a response.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata <= mem_q[addr];
      end
    end
  end

endmodule

// File: rtl/cprv_dmem_responder.sv
// Memory end of the CPU data-memory interface: single outstanding load/store with
// configurable read latency and valid/ready handshakes on request and response channels.
module cprv_dmem_responder
  import cprv_dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = 7,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_dmem_i,
  output logic                  ready_dmem_o,
  input  logic [ADDR_WIDTH-1:0] addr_dmem_i,
  input  logic [DATA_WIDTH-1:0] wdata_dmem_i,
  input  logic                  w_en_dmem_i,
  output logic                  valid_mem_dmem_o,
  input  logic                  ready_mem_dmem_i,
  output logic [DATA_WIDTH-1:0] rdata_dmem_o
);

  if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_lat_chk
    $error("cprv_dmem_responder: READ_LATENCY must be within 1..15");
  end

  dmem_state_t          state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;
  logic                 rd_seen_q, rd_seen_d;
  logic                 req_accept;
  logic [DATA_WIDTH-1:0] arr_rdata;

  // ready_q is high only in IDLE, so it alone qualifies an accept.
  assign req_accept = valid_dmem_i && ready_q;

  cprv_dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .en    (req_accept),
    .we    (w_en_dmem_i),
    .addr  (addr_dmem_i),
    .wdata (wdata_dmem_i),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DMEM_IDLE;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      rd_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      rd_seen_q <= rd_seen_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_seen_d = rd_seen_q;
    case (state_q)
      DMEM_IDLE: begin
        if (req_accept && !w_en_dmem_i) begin
          rd_seen_d = 1'b1;
          if (READ_LATENCY == 1) begin
            state_d = DMEM_RESP;
          end else begin
            cnt_d   = LAT_CNT_W'(READ_LATENCY - 2);
            state_d = DMEM_WAIT;
          end
        end
      end
      DMEM_WAIT: begin
        if (cnt_q == '0) begin
          state_d = DMEM_RESP;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      DMEM_RESP: begin
        if (ready_mem_dmem_i) begin
          state_d = DMEM_IDLE;
        end
      end
      default: state_d = DMEM_IDLE;
    endcase
    ready_d = (state_d == DMEM_IDLE);
    valid_d = (state_d == DMEM_RESP);
  end

  assign ready_dmem_o     = ready_q;
  assign valid_mem_dmem_o = valid_q;
  // Read register has no reset; mask it until the first load so reset shows zero data.
  assign rdata_dmem_o     = rd_seen_q ? arr_rdata : '0;

endmodule

// File: tb/tb_cprv_dmem_responder.sv
// Randomized self-checking bench: four responders (latency 1, 3, 4, 15) against an
// array-based memory model with latency and handshake expectations.
module tb_cprv_dmem_responder;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 7;
  localparam int NI = 4;
  localparam int DEPTH = 2 ** AW;

  function automatic int unsigned lat_of(input int k);
    case (k)
      0:       lat_of = 1;
      1:       lat_of = 3;
      2:       lat_of = 4;
      default: lat_of = 15;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  logic [NI-1:0] valid_i, wen_i, rready_i, ready_o, valid_o;
  logic [AW-1:0] addr_i  [NI];
  logic [DW-1:0] wdata_i [NI];
  logic [DW-1:0] rdata_o [NI];

  logic [DW-1:0] model_mem [NI][DEPTH];
  bit            written   [NI][DEPTH];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    cprv_dmem_responder #(
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .READ_LATENCY (lat_of(g))
    ) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .valid_dmem_i     (valid_i[g]),
      .ready_dmem_o     (ready_o[g]),
      .addr_dmem_i      (addr_i[g]),
      .wdata_dmem_i     (wdata_i[g]),
      .w_en_dmem_i      (wen_i[g]),
      .valid_mem_dmem_o (valid_o[g]),
      .ready_mem_dmem_i (rready_i[g]),
      .rdata_dmem_o     (rdata_o[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle_all(input string tag);
    for (int k = 0; k < NI; k++) begin
      check({tag, "_ready"}, 64'(ready_o[k]), 64'd1);
      check({tag, "_valid"}, 64'(valid_o[k]), 64'd0);
      check({tag, "_rdata"}, rdata_o[k], 64'd0);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge after the store edge.
  task automatic do_store(input int k, input int a, input logic [63:0] d);
    valid_i[k] = 1'b1; wen_i[k] = 1'b1; addr_i[k] = AW'(a); wdata_i[k] = d;
    check("st_ready", 64'(ready_o[k]), 64'd1);
    @(posedge clk);
    model_mem[k][a] = d;
    written[k][a] = 1'b1;
    @(negedge clk);
    valid_i[k] = 1'b0; wen_i[k] = 1'b0;
  endtask

  // Load with a measured latency, optional back-pressure of 'hold' cycles, then consume.
  task automatic do_load(input int k, input int a, input int hold);
    int n;
    logic [63:0] d0;
    valid_i[k] = 1'b1; wen_i[k] = 1'b0; addr_i[k] = AW'(a); rready_i[k] = 1'b0;
    check("ld_ready", 64'(ready_o[k]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    valid_i[k] = 1'b0;
    n = 1;
    while (!valid_o[k] && n < 40) begin
      check("wait_ready", 64'(ready_o[k]), 64'd0);
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(lat_of(k)));
    check("resp_valid", 64'(valid_o[k]), 64'd1);
    if (written[k][a]) check("ld_data", rdata_o[k], model_mem[k][a]);
    d0 = rdata_o[k];
    // Requests presented while busy must be ignored, including stores.
    valid_i[k] = 1'b1; wen_i[k] = 1'b1;
    addr_i[k] = AW'($urandom_range(0, DEPTH - 1)); wdata_i[k] = {$urandom, $urandom};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(valid_o[k]), 64'd1);
      check("hold_data", rdata_o[k], d0);
      check("hold_ready", 64'(ready_o[k]), 64'd0);
    end
    rready_i[k] = 1'b1;
    check("consume_ready", 64'(ready_o[k]), 64'd0);
    @(negedge clk);
    valid_i[k] = 1'b0; wen_i[k] = 1'b0; rready_i[k] = 1'b0;
    check("post_valid", 64'(valid_o[k]), 64'd0);
    check("post_ready", 64'(ready_o[k]), 64'd1);
  endtask

  // Issue a load, then reset while in WAIT (in_resp=0) or RESP (in_resp=1).
  task automatic reset_mid(input int k, input int a, input bit in_resp);
    int n;
    valid_i[k] = 1'b1; wen_i[k] = 1'b0; addr_i[k] = AW'(a); rready_i[k] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    valid_i[k] = 1'b0;
    if (in_resp) begin
      n = 1;
      while (!valid_o[k] && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("rm_in_resp", 64'(valid_o[k]), 64'd1);
    end else begin
      check("rm_in_wait", 64'(valid_o[k]), 64'd0);
    end
    #2 rst_n = 1'b0;
    #1 chk_idle_all("rm_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("rm_no_resp", 64'(valid_o[k]), 64'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    valid_i = '0; wen_i = '0; rready_i = '0;
    for (int k = 0; k < NI; k++) begin
      addr_i[k] = '0; wdata_i[k] = '0;
      for (int a = 0; a < DEPTH; a++) begin
        written[k][a] = 1'b0; model_mem[k][a] = '0;
      end
    end
    repeat (3) @(negedge clk);
    chk_idle_all("reset");
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) check("no_resp_after_rst", 64'(valid_o[k]), 64'd0);
    end

    // Store then load the same word on the very next cycle.
    do_store(0, 5, 64'hDEAD_BEEF_0123_4567);
    do_load(0, 5, 0);

    // Latency sweep across all instances.
    for (int k = 0; k < NI; k++) begin
      do_store(k, 10 + k, {$urandom, $urandom});
      do_load(k, 10 + k, 0);
    end

    // Full-range store burst, then read every word back.
    for (int k = 0; k < NI; k++) begin
      for (int a = 0; a < DEPTH; a++) do_store(k, a, {$urandom, $urandom});
      for (int a = 0; a < DEPTH; a++) do_load(k, a, 0);
    end

    // Back-pressure on the top address.
    do_load(0, 127, 6);

    // Random mix of stores and loads with random back-pressure.
    for (int it = 0; it < 80; it++) begin
      int k;
      int a;
      k = int'($urandom_range(0, NI - 1));
      a = int'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 1) begin
        do_store(k, a, {$urandom, $urandom});
        if ($urandom_range(0, 1) == 1) do_load(k, a, int'($urandom_range(0, 3)));
      end else begin
        do_load(k, a, int'($urandom_range(0, 3)));
      end
    end

    // Reset during WAIT and during RESP; stored contents must survive.
    reset_mid(2, 33, 1'b0);
    do_load(2, 33, 0);
    reset_mid(2, 44, 1'b1);
    do_load(2, 44, 0);
    do_load(0, 0, 0);
    do_load(3, 127, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
